// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the MIPS datapaths.
// Long ops run a fixed-latency countdown and commit HI/LO together when it expires.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pendHi_q, pendHi_d, pendLo_q, pendLo_d;

    logic signed [2*WIDTH-1:0] prodS;
    logic [2*WIDTH-1:0]        prodU;
    logic signed [WIDTH-1:0]   aS, bS, quotS, remS;
    logic [WIDTH-1:0]          bSafe, quotU, remU;
    logic                      divZero, divOvf;
    logic [WIDTH-1:0]          resHi, resLo;

    // Divisor is forced to 1 in the zero/overflow cases so the dividers never see
    // an undefined operation; those cases are replaced by fixed results below.
    always_comb begin
        divZero = (B == '0);
        divOvf  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
        bSafe   = (divZero || divOvf) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
        aS      = $signed(A);
        bS      = $signed(bSafe);
        prodS   = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
        prodU   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        quotS   = aS / bS;
        remS    = aS % bS;
        quotU   = A / bSafe;
        remU    = A % bSafe;
        resHi   = '0;
        resLo   = '0;
        case (op)
            OP_MULT: begin
                resHi = prodS[2*WIDTH-1:WIDTH];
                resLo = prodS[WIDTH-1:0];
            end
            OP_MULTU: begin
                resHi = prodU[2*WIDTH-1:WIDTH];
                resLo = prodU[WIDTH-1:0];
            end
            OP_DIV: begin
                if (divZero) begin
                    resHi = A;
                    resLo = '1;
                end else if (divOvf) begin
                    resHi = '0;
                    resLo = A;
                end else begin
                    resHi = remS;
                    resLo = quotS;
                end
            end
            OP_DIVU: begin
                resHi = divZero ? A  : remU;
                resLo = divZero ? '1 : quotU;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pendHi_d = pendHi_q;
        pendLo_d = pendLo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d  = RUN;
                            cnt_d    = (op == OP_MULT || op == OP_MULTU) ? CW'(MULT_LAT) : CW'(DIV_LAT);
                            pendHi_d = resHi;
                            pendLo_d = resLo;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = pendHi_q;
                    lo_d    = pendLo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pendHi_q <= '0;
            pendLo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pendHi_q <= pendHi_d;
            pendLo_q <= pendLo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: long-op results go through a scoreboard queue,
// each scenario task compares busy length and HI/LO against the popped entry.
module tb_md_unit;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = OP_NONE;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   testsRun = 0;
    int   testsFailed = 0;

    md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Independent reference: signed divide works on magnitudes and fixes signs afterwards.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] ma, mb, q, r;
        model = '0;
        case (o)
            OP_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                model = p;
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                model = p;
            end
            OP_DIV: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, a};
                else begin
                    ma = a[31] ? -a : a;
                    mb = b[31] ? -b : b;
                    q  = ma / mb;
                    r  = ma % mb;
                    model = {(a[31] ? -r : r), ((a[31] ^ b[31]) ? -q : q)};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eHi, input logic [31:0] eLo, input int lat);
        exp_t e;
        e.hi = eHi; e.lo = eLo; e.lat = lat;
        if (lat > 0) sb.push_back(e);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        testsRun++;
        if ({busy, HI, LO} !== 65'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got busy=%b HI=%h LO=%h want all zero", busy, HI, LO);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int n;
        applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        waitIdle(n);
        ex = sb.pop_front();
        testsRun++;
        if (n != ex.lat) begin testsFailed++; $display("[TB] FAIL mult_busy: got %0d want %0d", n, ex.lat); end
        testsRun++;
        if ({HI, LO} !== {ex.hi, ex.lo}) begin testsFailed++; $display("[TB] FAIL mult_result: got %h_%h want %h_%h", HI, LO, ex.hi, ex.lo); end
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 5);
        waitIdle(n);
        ex = sb.pop_front();
        testsRun++;
        if (n != ex.lat) begin testsFailed++; $display("[TB] FAIL multu_busy: got %0d want %0d", n, ex.lat); end
        testsRun++;
        if ({HI, LO} !== {ex.hi, ex.lo}) begin testsFailed++; $display("[TB] FAIL multu_result: got %h_%h want %h_%h", HI, LO, ex.hi, ex.lo); end
    endtask

    task automatic test_div();
        int n;
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        waitIdle(n);
        ex = sb.pop_front();
        testsRun++;
        if (n != ex.lat) begin testsFailed++; $display("[TB] FAIL div_busy: got %0d want %0d", n, ex.lat); end
        testsRun++;
        if ({HI, LO} !== {ex.hi, ex.lo}) begin testsFailed++; $display("[TB] FAIL div_result: got %h_%h want %h_%h", HI, LO, ex.hi, ex.lo); end
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        waitIdle(n);
        ex = sb.pop_front();
        testsRun++;
        if ({HI, LO} !== {ex.hi, ex.lo} || n != ex.lat) begin
            testsFailed++;
            $display("[TB] FAIL divu_result: got %h_%h busy %0d want %h_%h busy %0d", HI, LO, n, ex.hi, ex.lo, ex.lat);
        end
    endtask

    task automatic test_div_corner();
        int n;
        applyStimulus(OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 10);
        waitIdle(n);
        ex = sb.pop_front();
        testsRun++;
        if ({HI, LO} !== {ex.hi, ex.lo} || n != ex.lat) begin
            testsFailed++;
            $display("[TB] FAIL div_by_zero: got %h_%h busy %0d want %h_%h busy %0d", HI, LO, n, ex.hi, ex.lo, ex.lat);
        end
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        waitIdle(n);
        ex = sb.pop_front();
        testsRun++;
        if ({HI, LO} !== {ex.hi, ex.lo} || n != ex.lat) begin
            testsFailed++;
            $display("[TB] FAIL div_overflow: got %h_%h busy %0d want %h_%h busy %0d", HI, LO, n, ex.hi, ex.lo, ex.lat);
        end
    endtask

    // Starts issued while busy (including on the falling edge) must be dropped.
    task automatic test_ignore();
        logic [31:0] priorHi, priorLo;
        priorHi = HI;
        priorLo = LO;
        applyStimulus(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        for (int c = 1; c <= 5; c++) begin
            testsRun++;
            if (busy !== 1'b1 || HI !== priorHi || LO !== priorLo) begin
                testsFailed++;
                $display("[TB] FAIL hold_c%0d: got busy=%b %h_%h want busy=1 %h_%h", c, busy, HI, LO, priorHi, priorLo);
            end
            start = 1'b0; op = OP_NONE;
            if (c == 2) begin start = 1'b1; op = OP_MTHI; A = 32'h0000_DEAD; end
            if (c == 4) begin start = 1'b1; op = OP_DIV;  A = 32'd50; B = 32'd5; end
            if (c == 5) begin start = 1'b1; op = OP_MTLO; A = 32'h0000_5555; end
            @(negedge clk);
        end
        start = 1'b0; op = OP_NONE;
        ex = sb.pop_front();
        testsRun++;
        if (busy !== 1'b0 || {HI, LO} !== {ex.hi, ex.lo}) begin
            testsFailed++;
            $display("[TB] FAIL ignore_commit: got busy=%b %h_%h want busy=0 %h_%h", busy, HI, LO, ex.hi, ex.lo);
        end
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b0 || {HI, LO} !== {ex.hi, ex.lo}) begin
            testsFailed++;
            $display("[TB] FAIL ignore_after: got busy=%b %h_%h want busy=0 %h_%h", busy, HI, LO, ex.hi, ex.lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] priorLo;
        priorLo = LO;
        start = 1'b1; op = OP_MTHI; A = 32'hAAAA_5555;
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b0 || HI !== 32'hAAAA_5555 || LO !== priorLo) begin
            testsFailed++;
            $display("[TB] FAIL mthi: got busy=%b %h_%h want busy=0 aaaa5555_%h", busy, HI, LO, priorLo);
        end
        op = OP_MTLO; A = 32'h0F0F_0F0F;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        testsRun++;
        if (busy !== 1'b0 || {HI, LO} !== {32'hAAAA_5555, 32'h0F0F_0F0F}) begin
            testsFailed++;
            $display("[TB] FAIL mtlo: got busy=%b %h_%h want busy=0 aaaa5555_0f0f0f0f", busy, HI, LO);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        applyStimulus(OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 10);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        testsRun++;
        if ({busy, HI, LO} !== 65'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: got busy=%b %h_%h want all zero", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            testsRun++;
            if ({busy, HI, LO} !== 65'd0) begin
                testsFailed++;
                $display("[TB] FAIL stale_commit_c%0d: got busy=%b %h_%h want all zero", c, busy, HI, LO);
            end
        end
        applyStimulus(OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 5);
        waitIdle(n);
        ex = sb.pop_front();
        testsRun++;
        if ({HI, LO} !== {ex.hi, ex.lo} || n != ex.lat) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_mult: got %h_%h busy %0d want %h_%h busy %0d", HI, LO, n, ex.hi, ex.lo, ex.lat);
        end
    endtask

    // Each op is started at the first edge after the previous busy drops.
    task automatic test_back_to_back();
        int n;
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i == 3) b = 32'hFFFF_FFFF;
            m = model(o, a, b);
            applyStimulus(o, a, b, m[63:32], m[31:0], (o <= OP_MULTU) ? 5 : 10);
            waitIdle(n);
            ex = sb.pop_front();
            testsRun++;
            if ({HI, LO} !== {ex.hi, ex.lo} || n != ex.lat) begin
                testsFailed++;
                $display("[TB] FAIL b2b_%0d op%0d a=%h b=%h: got %h_%h busy %0d want %h_%h busy %0d",
                         i, o, a, b, HI, LO, n, ex.hi, ex.lo, ex.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_ignore();
        test_mthi_mtlo();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
